// File: rtl/rsync_pkg.sv
// Shared defaults and counter-width helper for the rsync_filt level synchronizer.
// Consumers import rsync_pkg::* for SYNC_LEN_DEF, FILT_LEN_DEF and filt_cnt_w().
package rsync_pkg;

  localparam int SYNC_LEN_DEF = 3;
  localparam int FILT_LEN_DEF = 4;

  function automatic int filt_cnt_w(int filt_len);
    return ($clog2(filt_len) < 1) ? 1 : $clog2(filt_len);
  endfunction

endpackage

// File: rtl/rsync_filt_ch.sv
// One channel: SYNC_LEN-flop sync chain, FILT_LEN stability filter, optional edge regs.
// in -> out latency is SYNC_LEN+FILT_LEN edges; no backpressure (free-running level path).
module rsync_filt_ch
  import rsync_pkg::*;
#(
  parameter int   SYNC_LEN = SYNC_LEN_DEF,
  parameter int   FILT_LEN = FILT_LEN_DEF,
  parameter logic RST_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int             CW      = filt_cnt_w(FILT_LEN);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

  logic [SYNC_LEN-1:0] s;
  logic [CW-1:0]       cnt;
  logic                ss;

  assign ss = s[SYNC_LEN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= {SYNC_LEN{RST_BIT}};
    end else begin
      s <= {s[SYNC_LEN-2:0], in};
    end
  end

  // cnt tracks consecutive cycles ss has disagreed with out; any agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= RST_BIT;
      cnt <= '0;
    end else if (ss == out) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      out <= ss;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef RSYNC_FILT_EDGE_EN
  logic flip;

  assign flip = (ss != out) && (cnt == CNT_MAX);

  // Registered alongside out so the pulse lines up with the first cycle of the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip & ss;
      fall <= flip & ~ss;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/rsync_filt.sv
// WIDTH independent synchronize-and-filter channels; rise/fall pulses exist only
// when RSYNC_FILT_EDGE_EN is defined, otherwise they are tied to 0.
module rsync_filt
  import rsync_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               SYNC_LEN = SYNC_LEN_DEF,
  parameter int               FILT_LEN = FILT_LEN_DEF,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (WIDTH < 1) begin : g_bad_width
    $error("rsync_filt: WIDTH must be >= 1");
  end
  if (SYNC_LEN < 2) begin : g_bad_sync
    $error("rsync_filt: SYNC_LEN must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("rsync_filt: FILT_LEN must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    rsync_filt_ch #(
      .SYNC_LEN (SYNC_LEN),
      .FILT_LEN (FILT_LEN),
      .RST_BIT  (RST_VAL[i])
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .in   (in[i]),
      .out  (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_rsync_filt.sv
// Bench for rsync_filt: three instances (3/4 RST 00, 3/4 RST A5, 2/1 RST 00) checked
// with directed scenarios and a random run against a sliding-window reference model.
module tb_rsync_filt;

`ifdef RSYNC_FILT_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] din    [3];
  logic [7:0] out_w  [3];
  logic [7:0] rise_w [3];
  logic [7:0] fall_w [3];

  int checks = 0;
  int errors = 0;

  rsync_filt #(.WIDTH(8), .SYNC_LEN(3), .FILT_LEN(4), .RST_VAL(8'h00)) u_a (
    .clk(clk), .rst(rst), .in(din[0]), .out(out_w[0]), .rise(rise_w[0]), .fall(fall_w[0]));
  rsync_filt #(.WIDTH(8), .SYNC_LEN(3), .FILT_LEN(4), .RST_VAL(8'hA5)) u_b (
    .clk(clk), .rst(rst), .in(din[1]), .out(out_w[1]), .rise(rise_w[1]), .fall(fall_w[1]));
  rsync_filt #(.WIDTH(8), .SYNC_LEN(2), .FILT_LEN(1), .RST_VAL(8'h00)) u_c (
    .clk(clk), .rst(rst), .in(din[2]), .out(out_w[2]), .rise(rise_w[2]), .fall(fall_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sl_of(int k);
    return (k == 2) ? 2 : 3;
  endfunction
  function automatic int fl_of(int k);
    return (k == 2) ? 1 : 4;
  endfunction
  function automatic logic [7:0] rv_of(int k);
    return (k == 1) ? 8'hA5 : 8'h00;
  endfunction

  // Reference model: out[b] flips once the last FILT_LEN synced samples all disagree with it.
  logic [7:0] m_pipe [3][4];
  logic [7:0] m_hist [3][4];
  int         m_nh   [3];
  logic [7:0] m_out  [3];
  logic [7:0] m_rise [3];
  logic [7:0] m_fall [3];
  logic [7:0] m_ss, m_nxt;
  logic       m_ok;

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int j = 0; j < 4; j++) begin
          m_pipe[k][j] = rv_of(k);
          m_hist[k][j] = 8'h00;
        end
        m_nh[k]   = 0;
        m_out[k]  = rv_of(k);
        m_rise[k] = 8'h00;
        m_fall[k] = 8'h00;
      end else begin
        m_ss = m_pipe[k][sl_of(k)-1];
        for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = m_ss;
        if (m_nh[k] < 4) m_nh[k] = m_nh[k] + 1;
        m_nxt = m_out[k];
        for (int b = 0; b < 8; b++) begin
          if (m_nh[k] >= fl_of(k)) begin
            m_ok = 1'b1;
            for (int j = 0; j < fl_of(k); j++)
              if (m_hist[k][j][b] == m_out[k][b]) m_ok = 1'b0;
            if (m_ok) m_nxt[b] = ~m_out[k][b];
          end
        end
        m_rise[k] = EDGE ? (m_nxt & ~m_out[k]) : 8'h00;
        m_fall[k] = EDGE ? (~m_nxt & m_out[k]) : 8'h00;
        m_out[k]  = m_nxt;
        for (int j = 3; j > 0; j--) m_pipe[k][j] = m_pipe[k][j-1];
        m_pipe[k][0] = din[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ((rise_w[k] & fall_w[k]) !== 8'h00) begin
        errors++;
        $display("FAIL rise_fall_overlap dut=%0d rise=%h fall=%h required_overlap=00",
                 k, rise_w[k], fall_w[k]);
      end
    end
  end

  task automatic test_reset;
    rst = 1'b0;
    din[0] = 8'h00; din[1] = 8'h00; din[2] = 8'h00;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_w[k] !== rv_of(k)) begin
        errors++; $display("FAIL reset_out dut=%0d got=%h exp=%h", k, out_w[k], rv_of(k));
      end
      checks++;
      if ((rise_w[k] | fall_w[k]) !== 8'h00) begin
        errors++; $display("FAIL reset_edges dut=%0d rise=%h fall=%h exp=00", k, rise_w[k], fall_w[k]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_latency;
    logic [7:0] want_o, want_r;
    int lat;
    lat = 3 + 4 - 1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk); din[0] = 8'h01;
      @(posedge clk); #1;
      want_o = (e >= lat) ? 8'h01 : 8'h00;
      want_r = (EDGE && e == lat) ? 8'h01 : 8'h00;
      checks++;
      if (out_w[0] !== want_o) begin
        errors++; $display("FAIL latency_out edge=%0d got=%h exp=%h", e, out_w[0], want_o);
      end
      checks++;
      if (rise_w[0] !== want_r || fall_w[0] !== 8'h00) begin
        errors++; $display("FAIL latency_edges edge=%0d rise=%h fall=%h exp_rise=%h exp_fall=00",
                           e, rise_w[0], fall_w[0], want_r);
      end
    end
    @(negedge clk); din[0] = 8'h00;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_glitch;
    int n_hi, n_r, n_f;
    logic want;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk); din[0] = (e < 3) ? 8'h02 : 8'h00;
      @(posedge clk); #1;
      checks++;
      if (out_w[0][1] !== 1'b0 || rise_w[0][1] !== 1'b0) begin
        errors++; $display("FAIL glitch3 edge=%0d out1=%b rise1=%b exp=0/0", e, out_w[0][1], rise_w[0][1]);
      end
    end
    n_hi = 0; n_r = 0; n_f = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk); din[0] = (e < 4) ? 8'h02 : 8'h00;
      @(posedge clk); #1;
      want = (e >= 6 && e <= 9);
      checks++;
      if (out_w[0][1] !== want) begin
        errors++; $display("FAIL glitch4_out edge=%0d got=%b exp=%b", e, out_w[0][1], want);
      end
      if (out_w[0][1] === 1'b1) n_hi++;
      if (rise_w[0][1] === 1'b1) n_r++;
      if (fall_w[0][1] === 1'b1) n_f++;
    end
    checks++;
    if (n_hi != 4 || n_r != int'(EDGE) || n_f != int'(EDGE)) begin
      errors++; $display("FAIL glitch4_counts high=%0d rise=%0d fall=%0d exp=4/%0d/%0d",
                         n_hi, n_r, n_f, EDGE, EDGE);
    end
  endtask

  task automatic test_restart;
    logic [7:0] pat;
    logic want_o, want_r;
    pat = 8'b1111_0111;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk); din[0] = (e < 8 && pat[e]) ? 8'h04 : 8'h00;
      @(posedge clk); #1;
      want_o = (e >= 10 && e <= 13);
      want_r = EDGE && (e == 10);
      checks++;
      if (out_w[0][2] !== want_o || rise_w[0][2] !== want_r) begin
        errors++; $display("FAIL restart edge=%0d out2=%b rise2=%b exp=%b/%b",
                           e, out_w[0][2], rise_w[0][2], want_o, want_r);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [7:0] want_o, want_r;
    @(negedge clk); din[1] = 8'hFF;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_w[1] !== 8'hA5 || rise_w[1] !== 8'h00 || fall_w[1] !== 8'h00) begin
      errors++; $display("FAIL async_rst_midcount out=%h rise=%h fall=%h exp=a5/00/00",
                         out_w[1], rise_w[1], fall_w[1]);
    end
    @(negedge clk); rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      want_o = (e >= 6) ? 8'hFF : 8'hA5;
      want_r = (EDGE && e == 6) ? 8'h5A : 8'h00;
      checks++;
      if (out_w[1] !== want_o) begin
        errors++; $display("FAIL post_rst_out edge=%0d got=%h exp=%h", e, out_w[1], want_o);
      end
      checks++;
      if (rise_w[1] !== want_r || fall_w[1] !== 8'h00) begin
        errors++; $display("FAIL post_rst_edges edge=%0d rise=%h fall=%h exp_rise=%h exp_fall=00",
                           e, rise_w[1], fall_w[1], want_r);
      end
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_w[1] !== 8'hA5 || fall_w[1] !== 8'h00 || rise_w[1] !== 8'h00) begin
      errors++; $display("FAIL async_rst_settled out=%h rise=%h fall=%h exp=a5/00/00",
                         out_w[1], rise_w[1], fall_w[1]);
    end
    @(negedge clk); rst = 1'b0; din[1] = 8'h00;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_nofilt;
    logic [7:0] want_o, want_r, want_f;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk); din[2] = (e < 5) ? 8'hFF : 8'h00;
      @(posedge clk); #1;
      want_o = (e >= 2 && e < 7) ? 8'hFF : 8'h00;
      want_r = (EDGE && e == 2) ? 8'hFF : 8'h00;
      want_f = (EDGE && e == 7) ? 8'hFF : 8'h00;
      checks++;
      if (out_w[2] !== want_o || rise_w[2] !== want_r || fall_w[2] !== want_f) begin
        errors++; $display("FAIL nofilt edge=%0d out=%h rise=%h fall=%h exp=%h/%h/%h",
                           e, out_w[2], rise_w[2], fall_w[2], want_o, want_r, want_f);
      end
    end
  endtask

  task automatic test_random;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 5) == 0) din[k][b] = ~din[k][b];
      if (cyc == 300) rst = 1'b1;
      if (cyc == 303) rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (out_w[k] !== m_out[k]) begin
          errors++; $display("FAIL rand_out cyc=%0d dut=%0d got=%h exp=%h", cyc, k, out_w[k], m_out[k]);
        end
        checks++;
        if (rise_w[k] !== m_rise[k] || fall_w[k] !== m_fall[k]) begin
          errors++; $display("FAIL rand_edges cyc=%0d dut=%0d rise=%h fall=%h exp=%h/%h",
                             cyc, k, rise_w[k], fall_w[k], m_rise[k], m_fall[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_restart;
    test_async_reset;
    test_nofilt;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
